// File: rtl/miter_lockstep_pkg.sv
// Shared types and helpers for the lockstep miter comparator.
package miter_lockstep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_ARMED   = 2'd2,
    ST_TRIPPED = 2'd3
  } cmp_state_e;

  localparam int CYC_W = 32;

  // Index width for an N-entry vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/miter_lockstep_prio.sv
// Lowest-set-bit priority encoder for the per-channel hit vector.
module miter_lockstep_prio
  import miter_lockstep_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]         hit,
  output logic [idx_w(N)-1:0]  idx,
  output logic                 any
);

  localparam int IW = idx_w(N);

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    idx = '0;
    any = |hit;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) idx = IW'(k);
    end
  end

endmodule

// File: rtl/miter_lockstep_cmp.sv
// Lockstep comparator between a reference and a mutated core instance.
// Flags divergence after a warm-up window, counts mismatch cycles with
// saturation and captures the first divergence for debug.
// Optional: define MITER_LOCKSTEP_ASSERT_EN to elaborate an immediate
// assertion that fires on every counted mismatch (formal target).
module miter_lockstep_cmp
  import miter_lockstep_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CH_W   = 32,
  parameter int WARMUP = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       en_i,
  input  logic [NUM_CH-1:0]          ch_mask_i,
  input  logic [NUM_CH*CH_W-1:0]     ref_i,
  input  logic [NUM_CH*CH_W-1:0]     uut_i,
  output logic                       mismatch_o,
  output logic                       fail_o,
  output logic [idx_w(NUM_CH)-1:0]   first_ch_o,
  output logic [CYC_W-1:0]           first_cyc_o,
  output logic [CH_W-1:0]            first_ref_o,
  output logic [CH_W-1:0]            first_uut_o,
  output logic [CNT_W-1:0]           mm_cnt_o,
  output logic [1:0]                 state_o
);

  localparam int IW   = idx_w(NUM_CH);
  localparam int WC_W = idx_w(WARMUP + 1);
  localparam logic [WC_W-1:0] WARM_LAST = (WARMUP > 0) ? WC_W'(WARMUP - 1) : '0;
  localparam cmp_state_e START_ST = (WARMUP == 0) ? ST_ARMED : ST_WARMUP;

  // Saturating increment so a long divergence never wraps the counter to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CH_W-1:0]   ref_ch_p0 [NUM_CH];
  logic [CH_W-1:0]   uut_ch_p0 [NUM_CH];
  logic [NUM_CH-1:0] hit_p0;
  logic [IW-1:0]     hit_idx_p0;
  logic              hit_any_p0;
  logic              armed_p0;
  logic              vld_p0;

  cmp_state_e        state_p1;
  logic [WC_W-1:0]   warm_cnt_p1;
  logic [CYC_W-1:0]  cyc_cnt_p1;

  // ---- stage p0: unpack channels and build the masked hit vector ----
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ref_ch_p0[k] = ref_i[k*CH_W +: CH_W];
      uut_ch_p0[k] = uut_i[k*CH_W +: CH_W];
      hit_p0[k]    = ch_mask_i[k] & (ref_ch_p0[k] != uut_ch_p0[k]);
    end
  end

  miter_lockstep_prio #(.N(NUM_CH)) u_prio (
    .hit (hit_p0),
    .idx (hit_idx_p0),
    .any (hit_any_p0)
  );

  assign armed_p0 = (state_p1 == ST_ARMED) || (state_p1 == ST_TRIPPED);
  // A counted mismatch: armed, enabled, and not overridden by clear.
  assign vld_p0   = en_i & armed_p0 & hit_any_p0 & ~clear_i;

  // ---- stage p1: FSM, counters and first-failure capture ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p1    <= ST_IDLE;
      warm_cnt_p1 <= '0;
      cyc_cnt_p1  <= '0;
      mismatch_o  <= 1'b0;
      fail_o      <= 1'b0;
      first_ch_o  <= '0;
      first_cyc_o <= '0;
      first_ref_o <= '0;
      first_uut_o <= '0;
      mm_cnt_o    <= '0;
    end else if (clear_i) begin
      state_p1    <= en_i ? START_ST : ST_IDLE;
      warm_cnt_p1 <= '0;
      cyc_cnt_p1  <= '0;
      mismatch_o  <= 1'b0;
      fail_o      <= 1'b0;
      first_ch_o  <= '0;
      first_cyc_o <= '0;
      first_ref_o <= '0;
      first_uut_o <= '0;
      mm_cnt_o    <= '0;
    end else begin
      mismatch_o <= vld_p0;
      if (vld_p0) mm_cnt_o <= sat_inc(mm_cnt_o);
      if (en_i && armed_p0) cyc_cnt_p1 <= cyc_cnt_p1 + 1'b1;
      case (state_p1)
        ST_IDLE: begin
          if (en_i) begin
            state_p1    <= START_ST;
            warm_cnt_p1 <= '0;
          end
        end
        ST_WARMUP: begin
          if (!en_i) begin
            state_p1    <= ST_IDLE;
            warm_cnt_p1 <= '0;
          end else if (warm_cnt_p1 == WARM_LAST) begin
            state_p1 <= ST_ARMED;
          end else begin
            warm_cnt_p1 <= warm_cnt_p1 + 1'b1;
          end
        end
        ST_ARMED: begin
          if (vld_p0) begin
            state_p1    <= ST_TRIPPED;
            fail_o      <= 1'b1;
            first_ch_o  <= hit_idx_p0;
            first_cyc_o <= cyc_cnt_p1;
            first_ref_o <= ref_ch_p0[hit_idx_p0];
            first_uut_o <= uut_ch_p0[hit_idx_p0];
          end
        end
        default: begin
          state_p1 <= ST_TRIPPED;
        end
      endcase
    end
  end

  assign state_o = state_p1;

`ifdef MITER_LOCKSTEP_ASSERT_EN
  // Fire on every counted mismatch; this is the property formal tries to break.
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!vld_p0);
  end
`endif

endmodule

// File: tb/tb_miter_lockstep_cmp.sv
// Self-checking bench for miter_lockstep_cmp: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_miter_lockstep_cmp;

  localparam int NUM_CH = 16;
  localparam int CH_W   = 32;
  localparam int WARMUP = 4;
  localparam int CNT_W  = 16;
  localparam int IW     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic en = 1'b0;
  logic [NUM_CH-1:0]      mask = '1;
  logic [NUM_CH*CH_W-1:0] ref_v = '0;
  logic [NUM_CH*CH_W-1:0] uut_v = '0;

  logic              mm_a, fail_a;
  logic [IW-1:0]     fch_a;
  logic [31:0]       fcyc_a;
  logic [CH_W-1:0]   fref_a, fuut_a;
  logic [CNT_W-1:0]  cnt_a;
  logic [1:0]        st_a;

  logic              mm_b, fail_b;
  logic [IW-1:0]     fch_b;
  logic [31:0]       fcyc_b;
  logic [CH_W-1:0]   fref_b, fuut_b;
  logic [1:0]        cnt_b;
  logic [1:0]        st_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  miter_lockstep_cmp #(.NUM_CH(NUM_CH), .CH_W(CH_W), .WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .en_i(en), .ch_mask_i(mask),
    .ref_i(ref_v), .uut_i(uut_v), .mismatch_o(mm_a), .fail_o(fail_a),
    .first_ch_o(fch_a), .first_cyc_o(fcyc_a), .first_ref_o(fref_a),
    .first_uut_o(fuut_a), .mm_cnt_o(cnt_a), .state_o(st_a)
  );

  miter_lockstep_cmp #(.NUM_CH(NUM_CH), .CH_W(CH_W), .WARMUP(WARMUP), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .en_i(en), .ch_mask_i(mask),
    .ref_i(ref_v), .uut_i(uut_v), .mismatch_o(mm_b), .fail_o(fail_b),
    .first_ch_o(fch_b), .first_cyc_o(fcyc_b), .first_ref_o(fref_b),
    .first_uut_o(fuut_b), .mm_cnt_o(cnt_b), .state_o(st_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 warming, 2 armed, 3 tripped.
  int          m_phase;
  int          m_wdone;
  logic [31:0] m_cyc;
  int          m_cnt;
  bit          m_mm, m_fail;
  int          m_ch;
  logic [31:0] m_fcyc, m_fref, m_fuut;

  task automatic m_zero();
    m_phase = 0; m_wdone = 0; m_cyc = '0; m_cnt = 0; m_mm = 0; m_fail = 0;
    m_ch = 0; m_fcyc = '0; m_fref = '0; m_fuut = '0;
  endtask

  always @(posedge clk or posedge rst) begin
    int first, prev;
    bit live;
    if (rst) begin
      m_zero();
    end else begin
      first = -1;
      for (int k = NUM_CH - 1; k >= 0; k--)
        if (mask[k] && (ref_v[k*CH_W +: CH_W] != uut_v[k*CH_W +: CH_W])) first = k;
      if (clear) begin
        m_zero();
        m_phase = en ? 1 : 0;
      end else begin
        prev = m_phase;
        live = en && (prev >= 2) && (first >= 0);
        m_mm = live;
        if (live) m_cnt++;
        if (live && prev == 2) begin
          m_fail  = 1;
          m_phase = 3;
          m_ch    = first;
          m_fcyc  = m_cyc;
          m_fref  = ref_v[first*CH_W +: CH_W];
          m_fuut  = uut_v[first*CH_W +: CH_W];
        end
        if (en && prev >= 2) m_cyc = m_cyc + 32'd1;
        if (prev == 0 && en) begin
          m_phase = 1;
          m_wdone = 0;
        end else if (prev == 1) begin
          if (!en) begin
            m_phase = 0;
            m_wdone = 0;
          end else begin
            m_wdone++;
            if (m_wdone == WARMUP) m_phase = 2;
          end
        end
      end
    end
  end

  // Every cycle, compare both instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("state",     st_a,   m_phase);
      chk("mismatch",  mm_a,   m_mm);
      chk("fail",      fail_a, m_fail);
      chk("first_ch",  fch_a,  m_ch);
      chk("first_cyc", fcyc_a, m_fcyc);
      chk("first_ref", fref_a, m_fref);
      chk("first_uut", fuut_a, m_fuut);
      chk("mm_cnt",    cnt_a,  (m_cnt > 65535) ? 65535 : m_cnt);
      chk("sat_state", st_b,   m_phase);
      chk("sat_fail",  fail_b, m_fail);
      chk("sat_ch",    fch_b,  m_ch);
      chk("sat_cnt",   cnt_b,  (m_cnt > 3) ? 3 : m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_same();
    for (int k = 0; k < NUM_CH; k++) ref_v[k*CH_W +: CH_W] = $urandom;
    uut_v = ref_v;
  endtask

  task automatic set_diff_5_9();
    ref_v[5*CH_W +: CH_W] = 32'hDEAD0000;
    uut_v[5*CH_W +: CH_W] = 32'hDEAD0001;
    ref_v[9*CH_W +: CH_W] = 32'h12345678;
    uut_v[9*CH_W +: CH_W] = 32'h87654321;
  endtask

  task automatic arm();
    set_same();
    clear = 1'b1;
    en    = 1'b1;
    step();
    clear = 1'b0;
    repeat (WARMUP) step();
    chk("arm_state", st_a, 2);
  endtask

  initial begin
    m_zero();
    set_same();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", st_a, 0);
    chk("rst_fail",  fail_a, 0);
    chk("rst_cnt",   cnt_a, 0);
    chk("rst_cyc",   fcyc_a, 0);
    @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Identical traffic, with one ignored mismatch on channel 3 during warm-up.
    en = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step();
      set_same();
      if (c == 2) uut_v[3*CH_W +: CH_W] = ~ref_v[3*CH_W +: CH_W];
      if (c == 4) chk("warm_state", st_a, 1);
      if (c == 5) chk("armed_at_5", st_a, 2);
    end
    chk("clean_fail", fail_a, 0);
    chk("clean_cnt",  cnt_a, 0);

    // Channels 5 and 9 diverge at armed cycle 10, held for 6 cycles.
    arm();
    repeat (10) step();
    set_diff_5_9();
    step();
    chk("t_fail",  fail_a, 1);
    chk("t_ch",    fch_a, 5);
    chk("t_cyc",   fcyc_a, 10);
    chk("t_ref",   fref_a, 32'hDEAD0000);
    chk("t_uut",   fuut_a, 32'hDEAD0001);
    chk("t_state", st_a, 3);
    repeat (5) step();
    chk("sat_cnt_lit", cnt_b, 3);
    chk("cnt6_lit",    cnt_a, 6);
    chk("keep_ch",     fch_a, 5);
    chk("keep_cyc",    fcyc_a, 10);

    // Clear together with a live mismatch.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_state", st_a, 1);
    chk("clr_fail",  fail_a, 0);
    chk("clr_cnt",   cnt_a, 0);
    chk("clr_mm",    mm_a, 0);

    // Channel 5 masked: channel 9 becomes the first failure.
    mask[5] = 1'b0;
    arm();
    repeat (10) step();
    set_diff_5_9();
    step();
    chk("m_ch",  fch_a, 9);
    chk("m_ref", fref_a, 32'h12345678);
    chk("m_uut", fuut_a, 32'h87654321);
    chk("m_cyc", fcyc_a, 10);
    mask = '1;

    // Asynchronous reset mid-operation.
    arm();
    repeat (3) step();
    uut_v[2*CH_W +: CH_W] = ~ref_v[2*CH_W +: CH_W];
    step();
    set_same();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_state", st_a, 0);
    chk("arst_fail",  fail_a, 0);
    chk("arst_cnt",   cnt_a, 0);
    chk("arst_ref",   fref_a, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_warm", st_a, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int k, b;
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
      mask  = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
      set_same();
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, NUM_CH - 1);
        b = $urandom_range(0, CH_W - 1);
        uut_v[k*CH_W + b] = ~uut_v[k*CH_W + b];
      end
      step();
    end
    clear = 1'b0;
    @(negedge clk);
    cmp_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miter_lockstep_cmp.md
# miter_lockstep_cmp

Parametrised lockstep comparator for mutation-coverage miters: samples NUM_CH output channels from a reference and a mutated core instance, flags divergence after a configurable warm-up window, and captures the first divergence for debug. Sits in the miter top between the two core instances, replacing per-signal immediate assertions with a registered, maskable, inspectable checker. The same block serves both simulation and formal flows.

## Interface
- NUM_CH, 16: number of compared channels.
- CH_W, 32: width of each channel; narrower signals are zero-extended by the instantiator.
- WARMUP, 4: cycles after arming during which mismatches are ignored.
- CNT_W, 16: width of the saturating mismatch counter.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous return to WARMUP; clears all capture state.
- en_i  in  1  compare enable, e.g. fetch_enable; comparison happens only while high.
- ch_mask_i  in  NUM_CH  per-channel enable; 0 excludes the channel.
- ref_i  in  NUM_CH*CH_W  reference outputs; channel k is bits [k*CH_W +: CH_W].
- uut_i  in  NUM_CH*CH_W  mutant outputs, same packing.
- mismatch_o  out  1  registered: a mismatch occurred in the previous cycle.
- fail_o  out  1  sticky: at least one counted mismatch since reset/clear.
- first_ch_o  out  $clog2(NUM_CH) (min 1)  lowest-index mismatching channel of the first failure.
- first_cyc_o  out  32  armed-cycle count at the first failure.
- first_ref_o, first_uut_o  out  CH_W  channel values at the first failure.
- mm_cnt_o  out  CNT_W  saturating count of cycles with ≥1 mismatch.
- state_o  out  2  current FSM state, encoded as in the package.

## Operation
- FSM states: IDLE(0), WARMUP(1), ARMED(2), TRIPPED(3).
- IDLE → WARMUP when en_i=1. WARMUP → ARMED when the warm-up counter reaches WARMUP-1 with en_i=1; WARMUP=0 goes IDLE → ARMED directly. ARMED → TRIPPED on the first counted mismatch. TRIPPED is terminal until clear_i or rst_i.
- en_i=0 in WARMUP returns to IDLE and zeroes the warm-up counter. en_i=0 in ARMED or TRIPPED holds the state and suppresses comparison.
- Per-cycle mismatch vector: hit[k] = ch_mask_i[k] & (ref_k != uut_k). A mismatch is counted only in ARMED or TRIPPED with en_i=1.
- First capture happens on the ARMED→TRIPPED transition only: lowest set index of hit, its ref/uut values, and the cycle counter. Later mismatches never overwrite the capture.
- Cycle counter: increments each cycle en_i=1 in ARMED/TRIPPED; 32-bit, wraps modulo 2^32.
- mm_cnt_o: increments per counted mismatch cycle and saturates at all-ones.
- clear_i has priority over every other event in the same cycle. clear_i zeroes all outputs and counters, then state goes to WARMUP if en_i=1, else IDLE.

## Timing
- All outputs are registered; response latency is exactly 1 cycle from the sampled inputs.
- Reset values: all outputs 0; state_o=IDLE.
- rst_i asserted mid-operation asynchronously zeroes every output the same instant; the first compare after release requires a fresh warm-up.
- Mismatch in the same cycle as the WARMUP→ARMED transition is not counted. Counting starts the following cycle.

## Configuration
- MITER_LOCKSTEP_ASSERT_EN defined: an immediate assertion fires on the clock edge when a counted mismatch is present (`assert (!counted)`). This is the formal target and the simulation error.
- Undefined: no assertions are elaborated; detection is reported only through the flag and capture outputs.

## Structure
- Package miter_lockstep_pkg holds:
  - the state enum, cmp_state_e;
  - the width constant for the cycle counter, CYC_W=32;
  - a function computing the index width, max(1, $clog2(N)).
- Sub-module miter_lockstep_prio: parametrised lowest-set-bit priority encoder. Inputs: the hit vector. Outputs: index and any flag.

## Test plan
- Identical inputs, WARMUP=4, en_i=1 for 100 cycles → state_o=ARMED at cycle 5, fail_o=0, mm_cnt_o=0.
- Mismatch on channel 3 during warm-up cycle 2 → ignored; fail_o=0.
- ARMED, channels 5 and 9 differ at armed cycle 10 (ref 0xDEAD0000, uut 0xDEAD0001 on channel 5) → next cycle fail_o=1, first_ch_o=5, first_cyc_o=10, first_ref_o=0xDEAD0000, first_uut_o=0xDEAD0001.
- Channel 5 masked, same stimulus → first_ch_o=9, with channel 9's values captured.
- CNT_W=2, mismatch for 6 consecutive cycles → mm_cnt_o saturates at 3; the capture remains from the first cycle.
- clear_i together with a mismatch → mismatch not counted, outputs 0, state WARMUP. rst_i pulse mid-ARMED → immediate zero outputs, state IDLE.
